// File: rtl/queue_pkg.sv
// Shared widths, limits and the wait-time helper for the bank-queue people counter.
package queue_pkg;

  localparam int unsigned PCOUNT_W   = 3;
  localparam int unsigned WTIME_W    = 5;
  localparam int unsigned TCOUNT_W   = 2;
  localparam int unsigned SVC_TIME   = 3;
  localparam int unsigned PCOUNT_MAX = (1 << PCOUNT_W) - 1;
  localparam int unsigned PROD_W     = PCOUNT_W + 4;
  localparam int unsigned SCALED_W   = PROD_W + 6;

  typedef enum logic {
    StIdle,
    StHigh
  } sensor_state_e;

  // floor(SVC_TIME * (p + T - 1) / T); T is 1..3, so /3 is a multiply by 43/128,
  // exact for every numerator below 128.
  function automatic logic [WTIME_W-1:0] wait_time(input logic [PCOUNT_W-1:0] pcount,
                                                   input logic [TCOUNT_W-1:0] tcount);
    logic [PROD_W-1:0]   t_eff;
    logic [PROD_W-1:0]   num;
    logic [SCALED_W-1:0] scaled;
    logic [PROD_W-1:0]   quot;
    t_eff  = (tcount == '0) ? PROD_W'(1) : PROD_W'(tcount);
    num    = PROD_W'(SVC_TIME) * (PROD_W'(pcount) + t_eff - PROD_W'(1));
    scaled = SCALED_W'(num) * SCALED_W'(43);
    unique case (t_eff)
      PROD_W'(2): quot = num >> 1;
      PROD_W'(3): quot = PROD_W'(scaled >> 7);
      default:    quot = num;
    endcase
    if (pcount == '0) begin
      quot = '0;
    end
    return WTIME_W'(quot);
  endfunction

endpackage

// File: rtl/sensor_edge_sync.sv
// Photocell synchroniser and rising-edge qualifier producing a one-cycle event pulse.
module sensor_edge_sync
  import queue_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor,
  output logic pulse
);

  localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic                   armed_q, armed_d;
  sensor_state_e          state_q, state_d;
  logic                   level;
  logic                   valid;

  assign level = sync_q[SYNC_STAGES-1];
  assign valid = (fill_q == FILL_W'(SYNC_STAGES));

  // The cleared chain reads low for SYNC_STAGES cycles after reset; only a genuine
  // low seen once the chain is filled arms the detector, so a beam held across
  // reset has to fall and rise again before it counts.
  always_comb begin
    fill_d  = valid ? fill_q : fill_q + 1'b1;
    armed_d = armed_q | (valid & ~level);
  end

  always_comb begin
    state_d = state_q;
    pulse   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (level && armed_q) begin
          state_d = StHigh;
          pulse   = 1'b1;
        end
      end
      StHigh: begin
        if (!level) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      fill_q  <= '0;
      armed_q <= 1'b0;
      state_q <= StIdle;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sensor};
      fill_q  <= fill_d;
      armed_q <= armed_d;
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/queue_counter.sv
// Bank-queue people counter: arrivals/departures from two photocells, saturating
// count with flags, and a registered wait-time estimate for the display decoder.
module queue_counter
  import queue_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                front_sensor,
  input  logic                back_sensor,
  input  logic [TCOUNT_W-1:0] Tcount,
  output logic [PCOUNT_W-1:0] Pcount,
  output logic [WTIME_W-1:0]  Wtime,
  output logic                full_flag,
  output logic                empty_flag
);

  logic [1:0]          rst_sync_q;
  logic                rst_int;
  logic                arr;
  logic                dep;
  logic [PCOUNT_W-1:0] pcount_q, pcount_d;
  logic [WTIME_W-1:0]  wtime_q, wtime_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;

  // Reset asserts immediately, releases two clean edges after rst falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign rst_int = rst_sync_q[1];

  sensor_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_front (
    .clk   (clk),
    .rst   (rst_int),
    .sensor(front_sensor),
    .pulse (arr)
  );

  sensor_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_back (
    .clk   (clk),
    .rst   (rst_int),
    .sensor(back_sensor),
    .pulse (dep)
  );

  always_comb begin
    pcount_d = pcount_q;
    if (arr && !dep && !full_q) begin
      pcount_d = pcount_q + 1'b1;
    end else if (dep && !arr && !empty_q) begin
      pcount_d = pcount_q - 1'b1;
    end
    full_d  = (pcount_d == PCOUNT_W'(PCOUNT_MAX));
    empty_d = (pcount_d == '0);
    wtime_d = wait_time(pcount_q, Tcount);
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      pcount_q <= '0;
      wtime_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      pcount_q <= pcount_d;
      wtime_q  <= wtime_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign Pcount     = pcount_q;
  assign Wtime      = wtime_q;
  assign full_flag  = full_q;
  assign empty_flag = empty_q;

endmodule

// File: tb/tb_queue_counter.sv
// Bench for queue_counter: directed scenarios plus random sensor traffic, all checked
// every cycle against a sample-history reference model.
module tb_queue_counter;

  logic       clk;
  logic       rst;
  logic       front_sensor;
  logic       back_sensor;
  logic [1:0] tcount;
  logic [2:0] pcount;
  logic [4:0] wtime;
  logic       full_flag;
  logic       empty_flag;

  int unsigned n_vec;
  int unsigned n_err;

  // Reference model state
  int m_pcount;
  int m_wtime;
  int rel_edges;
  int fh[3];
  int bh[3];

  queue_counter u_dut (
    .clk         (clk),
    .rst         (rst),
    .front_sensor(front_sensor),
    .back_sensor (back_sensor),
    .Tcount      (tcount),
    .Pcount      (pcount),
    .Wtime       (wtime),
    .full_flag   (full_flag),
    .empty_flag  (empty_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_wait(input int p, input int t);
    int tt;
    tt = (t == 0) ? 1 : t;
    if (p == 0) return 0;
    return (3 * (p + tt - 1)) / tt;
  endfunction

  task automatic model_reset();
    m_pcount  = 0;
    m_wtime   = 0;
    rel_edges = 0;
    for (int i = 0; i < 3; i++) begin
      fh[i] = -1;
      bh[i] = -1;
    end
  endtask

  // A sensor sample taken at functional edge n becomes an event at edge n+2 when the
  // preceding sample (also taken after reset) was low.
  task automatic model_edge();
    bit arr;
    bit dep;
    int new_w;
    if (rst) begin
      model_reset();
      return;
    end
    rel_edges++;
    if (rel_edges <= 2) return;
    arr   = (fh[1] == 1) && (fh[2] == 0);
    dep   = (bh[1] == 1) && (bh[2] == 0);
    new_w = ref_wait(m_pcount, int'(tcount));
    if (arr && !dep && m_pcount < 7) m_pcount++;
    else if (dep && !arr && m_pcount > 0) m_pcount--;
    m_wtime = new_w;
    fh[2] = fh[1];
    fh[1] = fh[0];
    fh[0] = int'(front_sensor);
    bh[2] = bh[1];
    bh[1] = bh[0];
    bh[0] = int'(back_sensor);
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".pcount"}, 32'(pcount), 32'(m_pcount));
    check_eq({tag, ".wtime"}, 32'(wtime), 32'(m_wtime));
    check_eq({tag, ".full"}, 32'(full_flag), 32'(m_pcount == 7));
    check_eq({tag, ".empty"}, 32'(empty_flag), 32'(m_pcount == 0));
  endtask

  task automatic tick(input logic f, input logic b, input logic [1:0] t);
    front_sensor = f;
    back_sensor  = b;
    tcount       = t;
    @(posedge clk);
    model_edge();
    #1;
    check_all("cyc");
  endtask

  task automatic hold(input logic f, input logic b, input logic [1:0] t, input int n);
    for (int i = 0; i < n; i++) tick(f, b, t);
  endtask

  task automatic pulses(input logic f, input logic b, input logic [1:0] t, input int n);
    for (int i = 0; i < n; i++) begin
      hold(f, b, t, 5);
      hold(1'b0, 1'b0, t, 5);
    end
  endtask

  // Called 1ns after a posedge: asserts reset mid-cycle and checks the async clear.
  task automatic async_reset(input logic f, input logic b, input logic [1:0] t);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("rst_async");
    hold(f, b, t, 2);
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    front_sensor = 1'b0;
    back_sensor  = 1'b0;
    tcount       = 2'd1;
    rst          = 1'b0;
    model_reset();
    #1;
    rst = 1'b1;
    #1;
    check_all("rst_init");
    hold(1'b0, 1'b0, 2'd1, 3);
    rst = 1'b0;
    hold(1'b0, 1'b0, 2'd1, 5);

    // Three arrivals with one teller
    pulses(1'b1, 1'b0, 2'd1, 3);
    check_eq("three_arr.pcount", 32'(pcount), 32'd3);
    check_eq("three_arr.wtime", 32'(wtime), 32'd9);

    // Down to two, then vary the teller count with no sensor activity
    pulses(1'b0, 1'b1, 2'd1, 1);
    hold(1'b0, 1'b0, 2'd2, 3);
    check_eq("t2.wtime", 32'(wtime), 32'd4);
    hold(1'b0, 1'b0, 2'd0, 3);
    check_eq("t0.wtime", 32'(wtime), 32'd6);
    check_eq("t0.pcount", 32'(pcount), 32'd2);

    // Drain and push two extra departures at empty
    pulses(1'b0, 1'b1, 2'd1, 4);
    check_eq("sat_empty.pcount", 32'(pcount), 32'd0);
    check_eq("sat_empty.flag", 32'(empty_flag), 32'd1);

    // Nine arrivals saturate at seven
    pulses(1'b1, 1'b0, 2'd1, 9);
    check_eq("sat_full.pcount", 32'(pcount), 32'd7);
    check_eq("sat_full.flag", 32'(full_flag), 32'd1);
    check_eq("sat_full.wtime", 32'(wtime), 32'd21);

    // Four customers, three tellers, simultaneous arrival and departure
    pulses(1'b0, 1'b1, 2'd3, 3);
    pulses(1'b1, 1'b1, 2'd3, 1);
    check_eq("cancel.pcount", 32'(pcount), 32'd4);
    check_eq("cancel.wtime", 32'(wtime), 32'd6);
    hold(1'b1, 1'b0, 2'd3, 50);
    hold(1'b0, 1'b0, 2'd3, 4);
    check_eq("long_hold.pcount", 32'(pcount), 32'd5);
    check_eq("long_hold.wtime", 32'(wtime), 32'd7);

    // Reset with the front beam broken; no count until it falls and rises
    hold(1'b1, 1'b0, 2'd3, 3);
    async_reset(1'b1, 1'b0, 2'd3);
    hold(1'b1, 1'b0, 2'd3, 10);
    check_eq("rst_held.pcount", 32'(pcount), 32'd0);
    hold(1'b0, 1'b0, 2'd3, 3);
    hold(1'b1, 1'b0, 2'd3, 4);
    check_eq("rst_rearm.pcount", 32'(pcount), 32'd1);

    // Random traffic
    begin
      logic       f;
      logic       b;
      logic [1:0] t;
      f = 1'b0;
      b = 1'b0;
      t = 2'd1;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 3) == 0) f = ~f;
        if ($urandom_range(0, 4) == 0) b = ~b;
        if ($urandom_range(0, 19) == 0) t = 2'($urandom_range(0, 3));
        tick(f, b, t);
        if ($urandom_range(0, 299) == 0) async_reset(f, b, t);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
